// File: rtl/pmod_dac_serializer.sv
// pmod_dac_serializer
//   N-channel serializer for DAC121S101-class SPI DACs. One shared SCLK/SYNC
//   pair drives NUM_CH DIN lines; each frame shifts one DATA_W-bit word per
//   channel, MSB first. A one-deep holding buffer with valid/ready decouples
//   the data source from frame timing.
//
// Ports
//   CLK_i, RST_i      clock, synchronous active-high reset
//   MODE_i            0 = continuous refresh, 1 = on-demand
//   DATA_i            channel c at [c*DATA_W +: DATA_W]
//   DATA_VALID_i      DATA_i valid; accepted when DATA_READY_o also high
//   DATA_READY_o      holding buffer empty
//   DAC_SCLK_o        serial clock (registered pin)
//   DAC_SYNC_o        frame sync, low while shifting (registered pin)
//   DAC_DIN_o         per-channel serial data (registered pins)
//   BUSY_o            high in LOAD/SHIFT/GAP
//   FRAME_DONE_o      one-cycle pulse on the first GAP cycle

// Per-channel datapath: holding word, last transmitted word, shift register.
module pmod_dac_lane #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              load_new,
    input  logic              load_old,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] data_i,
    output logic              msb_o
);
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] sh_q, sh_d;

    always_comb begin
        hold_d = hold_q;
        last_d = last_q;
        sh_d   = sh_q;
        if (accept) hold_d = data_i;
        if (load_new) begin
            sh_d   = hold_q;
            last_d = hold_q;
        end else if (load_old) begin
            sh_d = last_q;
        end else if (shift_en) begin
            sh_d = {sh_q[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            last_q <= '0;
            sh_q   <= '0;
        end else begin
            hold_q <= hold_d;
            last_q <= last_d;
            sh_q   <= sh_d;
        end
    end

    assign msb_o = sh_q[DATA_W-1];
endmodule

module pmod_dac_serializer #(
    parameter int NUM_CH      = 2,
    parameter int DATA_W      = 16,
    parameter int SCLK_HALF   = 5,
    parameter int SYNC_HI     = 4,
    parameter int SYNC_GAP    = 36,
    parameter int STARTUP_CYC = 8001
) (
    input  logic                     CLK_i,
    input  logic                     RST_i,
    input  logic                     MODE_i,
    input  logic [NUM_CH*DATA_W-1:0] DATA_i,
    input  logic                     DATA_VALID_i,
    output logic                     DATA_READY_o,
    output logic                     DAC_SCLK_o,
    output logic                     DAC_SYNC_o,
    output logic [NUM_CH-1:0]        DAC_DIN_o,
    output logic                     BUSY_o,
    output logic                     FRAME_DONE_o
);
    localparam int BIT_LEN = 2 * SCLK_HALF;
    localparam int M1      = (STARTUP_CYC > SYNC_GAP) ? STARTUP_CYC : SYNC_GAP;
    localparam int M2      = (SYNC_HI > BIT_LEN) ? SYNC_HI : BIT_LEN;
    localparam int MAXC    = (M1 > M2) ? M1 : M2;
    localparam int CW      = $clog2(MAXC);
    localparam int BW      = $clog2(DATA_W);

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            pending_q, pending_d;
    logic            sclk_q, sclk_d;
    logic            sync_q, sync_d;
    logic [NUM_CH-1:0] din_q, din_d;

    logic              accept, pend_any;
    logic              load_new, load_old, shift_en;
    logic [NUM_CH-1:0] lane_msb;

    assign accept   = DATA_VALID_i && !pending_q;
    // A word arriving on a decision cycle counts, so on-demand starts at once.
    assign pend_any = pending_q || accept;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        load_new = 1'b0;
        load_old = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            ST_STARTUP: begin
                if (cnt_q == CW'(STARTUP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = (!MODE_i || pend_any) ? ST_LOAD : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_IDLE: begin
                if (pend_any) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Snapshot on the first LOAD cycle; empty buffer means resend.
                if (cnt_q == '0) begin
                    load_new = pending_q;
                    load_old = !pending_q;
                end
                if (cnt_q == CW'(SYNC_HI - 1)) begin
                    cnt_d   = '0;
                    bit_d   = BW'(DATA_W - 1);
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CW'(BIT_LEN - 1)) begin
                    cnt_d = '0;
                    // Last bit is not shifted out so DIN holds it through GAP.
                    if (bit_q == '0) begin
                        state_d = ST_GAP;
                    end else begin
                        bit_d    = bit_q - BW'(1);
                        shift_en = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == CW'(SYNC_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = (!MODE_i || pend_any) ? ST_LOAD : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_STARTUP;
        endcase
    end

    always_comb begin
        pending_d = pending_q;
        if (load_new) pending_d = 1'b0;
        if (accept)   pending_d = 1'b1;
    end

    // Pin values one cycle ahead of the IOB register.
    always_comb begin
        sclk_d = (state_q == ST_SHIFT) && (cnt_q < CW'(SCLK_HALF));
        sync_d = (state_q != ST_SHIFT);
        din_d  = (state_q == ST_SHIFT) ? lane_msb : din_q;
    end

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_q   <= ST_STARTUP;
            cnt_q     <= '0;
            bit_q     <= '0;
            pending_q <= 1'b0;
            sclk_q    <= 1'b0;
            sync_q    <= 1'b1;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            pending_q <= pending_d;
            sclk_q    <= sclk_d;
            sync_q    <= sync_d;
            din_q     <= din_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        pmod_dac_lane #(.DATA_W(DATA_W)) u_lane (
            .clk      (CLK_i),
            .rst      (RST_i),
            .accept   (accept),
            .load_new (load_new),
            .load_old (load_old),
            .shift_en (shift_en),
            .data_i   (DATA_i[c*DATA_W +: DATA_W]),
            .msb_o    (lane_msb[c])
        );
    end

    assign DAC_SCLK_o   = sclk_q;
    assign DAC_SYNC_o   = sync_q;
    assign DAC_DIN_o    = din_q;
    assign DATA_READY_o = !pending_q;
    assign BUSY_o       = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_GAP);
    assign FRAME_DONE_o = (state_q == ST_GAP) && (cnt_q == '0);
endmodule

// File: tb/tb_pmod_dac_serializer.sv
module tb_pmod_dac_serializer;
    localparam int NUM_CH      = 2;
    localparam int DATA_W      = 16;
    localparam int SCLK_HALF   = 5;
    localparam int SYNC_HI     = 4;
    localparam int SYNC_GAP    = 36;
    localparam int STARTUP_CYC = 8001;

    logic                     CLK_i = 1'b0;
    logic                     RST_i = 1'b1;
    logic                     MODE_i = 1'b0;
    logic [NUM_CH*DATA_W-1:0] DATA_i = '0;
    logic                     DATA_VALID_i = 1'b0;
    logic                     DATA_READY_o;
    logic                     DAC_SCLK_o;
    logic                     DAC_SYNC_o;
    logic [NUM_CH-1:0]        DAC_DIN_o;
    logic                     BUSY_o;
    logic                     FRAME_DONE_o;

    int vec  = 0;
    int errs = 0;
    int fd_cnt = 0;

    always #5 CLK_i = ~CLK_i;

    always @(posedge CLK_i) if (FRAME_DONE_o === 1'b1) fd_cnt <= fd_cnt + 1;

    pmod_dac_serializer #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SCLK_HALF(SCLK_HALF),
        .SYNC_HI(SYNC_HI), .SYNC_GAP(SYNC_GAP), .STARTUP_CYC(STARTUP_CYC)
    ) dut (
        .CLK_i(CLK_i), .RST_i(RST_i), .MODE_i(MODE_i), .DATA_i(DATA_i),
        .DATA_VALID_i(DATA_VALID_i), .DATA_READY_o(DATA_READY_o),
        .DAC_SCLK_o(DAC_SCLK_o), .DAC_SYNC_o(DAC_SYNC_o), .DAC_DIN_o(DAC_DIN_o),
        .BUSY_o(BUSY_o), .FRAME_DONE_o(FRAME_DONE_o)
    );

    task automatic tick;
        @(posedge CLK_i);
        #1;
    endtask

    task automatic do_reset(input logic mode);
        RST_i = 1'b1; MODE_i = mode; DATA_VALID_i = 1'b0; DATA_i = '0;
        tick; tick; tick;
        RST_i = 1'b0;
    endtask

    // Waits for the next SYNC fall, captures DATA_W bits on falling SCLK
    // edges, then returns once SYNC is high again.
    task automatic get_frame(output logic [NUM_CH-1:0][DATA_W-1:0] w, output bit ok);
        int budget = 20000;
        bit seen_hi = 1'b0;
        int nb = 0;
        logic ps;
        w = '0;
        while (budget > 0 && !(seen_hi && DAC_SYNC_o === 1'b0)) begin
            if (DAC_SYNC_o === 1'b1) seen_hi = 1'b1;
            tick; budget--;
        end
        ps = DAC_SCLK_o;
        while (budget > 0 && nb < DATA_W) begin
            tick; budget--;
            if (ps === 1'b1 && DAC_SCLK_o === 1'b0) begin
                for (int c = 0; c < NUM_CH; c++) w[c] = {w[c][DATA_W-2:0], DAC_DIN_o[c]};
                nb++;
            end
            ps = DAC_SCLK_o;
        end
        while (budget > 0 && DAC_SYNC_o !== 1'b1) begin tick; budget--; end
        ok = (budget > 0);
    endtask

    task automatic test_reset;
        RST_i = 1'b1; MODE_i = 1'b0; DATA_VALID_i = 1'b0; DATA_i = '0;
        tick; tick;
        vec++; if (DAC_SCLK_o !== 1'b0) begin errs++; $display("FAIL reset_sclk got %b want 0", DAC_SCLK_o); end
        vec++; if (DAC_SYNC_o !== 1'b1) begin errs++; $display("FAIL reset_sync got %b want 1", DAC_SYNC_o); end
        vec++; if (DAC_DIN_o !== 2'b00) begin errs++; $display("FAIL reset_din got %b want 00", DAC_DIN_o); end
        vec++; if (BUSY_o !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", BUSY_o); end
        vec++; if (FRAME_DONE_o !== 1'b0) begin errs++; $display("FAIL reset_fdone got %b want 0", FRAME_DONE_o); end
        vec++; if (DATA_READY_o !== 1'b1) begin errs++; $display("FAIL reset_ready got %b want 1", DATA_READY_o); end
    endtask

    // Continues from test_reset: reset still sampled high on the last edge.
    task automatic test_startup;
        int n = 0;
        int rises = 0, first_rise = -1, last_rise = -1, hi_cnt = 0, next_fall = -1;
        logic din_or = 1'b0;
        logic ps = 1'b0, psync = 1'b0;
        RST_i = 1'b0;
        while (DAC_SYNC_o !== 1'b0 && n < 20000) begin tick; n++; end
        vec++;
        if (n - 1 != STARTUP_CYC + SYNC_HI) begin
            errs++; $display("FAIL startup_sync_high got %0d want %0d", n - 1, STARTUP_CYC + SYNC_HI);
        end
        for (int t = 0; t < 260; t++) begin
            if (t < 200) begin
                if (DAC_SCLK_o === 1'b1 && ps === 1'b0) begin
                    if (first_rise < 0) first_rise = t;
                    last_rise = t;
                    rises++;
                end
                if (DAC_SCLK_o === 1'b1) hi_cnt++;
                din_or = din_or | (|DAC_DIN_o);
            end
            if (t > 0 && psync === 1'b1 && DAC_SYNC_o === 1'b0 && next_fall < 0) next_fall = t;
            ps = DAC_SCLK_o; psync = DAC_SYNC_o;
            tick;
        end
        vec++; if (rises != 16) begin errs++; $display("FAIL startup_pulses got %0d want 16", rises); end
        vec++; if (first_rise != 0) begin errs++; $display("FAIL startup_first_rise got %0d want 0", first_rise); end
        vec++; if (last_rise - first_rise != 150) begin errs++; $display("FAIL startup_sclk_period got %0d want 150", last_rise - first_rise); end
        vec++; if (hi_cnt != 80) begin errs++; $display("FAIL startup_sclk_high got %0d want 80", hi_cnt); end
        vec++; if (din_or !== 1'b0) begin errs++; $display("FAIL startup_din got %b want 0", din_or); end
        vec++; if (next_fall != 200) begin errs++; $display("FAIL startup_frame_period got %0d want 200", next_fall); end
    endtask

    task automatic test_bit_order;
        logic [NUM_CH-1:0][DATA_W-1:0] w;
        bit ok;
        int fd0;
        do_reset(1'b0);
        DATA_i = {16'h0FFF, 16'h0A5C}; DATA_VALID_i = 1'b1;
        tick;
        DATA_VALID_i = 1'b0;
        vec++; if (DATA_READY_o !== 1'b0) begin errs++; $display("FAIL bo_ready_low got %b want 0", DATA_READY_o); end
        fd0 = fd_cnt;
        get_frame(w, ok);
        vec++; if (!ok) begin errs++; $display("FAIL bo_timeout got timeout want frame"); end
        vec++; if (w[0] !== 16'h0A5C) begin errs++; $display("FAIL bo_din0 got %h want 0a5c", w[0]); end
        vec++; if (w[1] !== 16'h0FFF) begin errs++; $display("FAIL bo_din1 got %h want 0fff", w[1]); end
        vec++; if (fd_cnt - fd0 != 1) begin errs++; $display("FAIL bo_frame_done got %0d want 1", fd_cnt - fd0); end
        vec++; if (DATA_READY_o !== 1'b1) begin errs++; $display("FAIL bo_ready_high got %b want 1", DATA_READY_o); end
    endtask

    // Runs straight after test_bit_order, inside that frame's GAP.
    task automatic test_continuous;
        logic [NUM_CH-1:0][DATA_W-1:0] w;
        bit ok;
        DATA_i = {16'h0001, 16'h0800}; DATA_VALID_i = 1'b1;
        tick;
        DATA_VALID_i = 1'b0;
        for (int f = 0; f < 3; f++) begin
            get_frame(w, ok);
            vec++; if (!ok) begin errs++; $display("FAIL cont_timeout frame %0d got timeout want frame", f); end
            vec++; if (w[0] !== 16'h0800) begin errs++; $display("FAIL cont_din0 frame %0d got %h want 0800", f, w[0]); end
            vec++; if (w[1] !== 16'h0001) begin errs++; $display("FAIL cont_din1 frame %0d got %h want 0001", f, w[1]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [NUM_CH-1:0][DATA_W-1:0] w;
        bit ok;
        bit done = 1'b0;
        int k = 0;
        do_reset(1'b0);
        fork
            begin : drv
                int budget = 30000;
                logic acc;
                DATA_i = {16'h2000, 16'h1000}; DATA_VALID_i = 1'b1;
                while (!done && budget > 0) begin
                    acc = DATA_READY_o;
                    tick; budget--;
                    if (acc === 1'b1) begin
                        k++;
                        DATA_i = {16'(16'h2000 + k), 16'(16'h1000 + k)};
                    end
                end
                DATA_VALID_i = 1'b0;
            end
            begin : cap
                for (int f = 0; f < 4; f++) begin
                    get_frame(w, ok);
                    vec++; if (!ok) begin errs++; $display("FAIL b2b_timeout frame %0d got timeout want frame", f); end
                    vec++; if (w[0] !== 16'(16'h1000 + f)) begin errs++; $display("FAIL b2b_din0 frame %0d got %h want %h", f, w[0], 16'(16'h1000 + f)); end
                    vec++; if (w[1] !== 16'(16'h2000 + f)) begin errs++; $display("FAIL b2b_din1 frame %0d got %h want %h", f, w[1], 16'(16'h2000 + f)); end
                end
                done = 1'b1;
            end
        join
        vec++; if (k != 5) begin errs++; $display("FAIL b2b_accept_count got %0d want 5", k); end
        vec++; if (DATA_READY_o !== 1'b0) begin errs++; $display("FAIL b2b_ready_pending got %b want 0", DATA_READY_o); end
    endtask

    task automatic test_on_demand;
        logic [NUM_CH-1:0][DATA_W-1:0] w;
        bit ok;
        int fd0, lows = 0;
        do_reset(1'b1);
        for (int i = 0; i < STARTUP_CYC + 10; i++) tick;
        vec++; if (BUSY_o !== 1'b0) begin errs++; $display("FAIL od_idle_busy got %b want 0", BUSY_o); end
        vec++; if (DAC_SYNC_o !== 1'b1) begin errs++; $display("FAIL od_idle_sync got %b want 1", DAC_SYNC_o); end
        DATA_i = {16'h0000, 16'h0123}; DATA_VALID_i = 1'b1;
        tick;
        DATA_VALID_i = 1'b0;
        vec++; if (BUSY_o !== 1'b1) begin errs++; $display("FAIL od_start_busy got %b want 1", BUSY_o); end
        fd0 = fd_cnt;
        get_frame(w, ok);
        vec++; if (!ok || w[0] !== 16'h0123 || w[1] !== 16'h0000) begin
            errs++; $display("FAIL od_word1 got ok=%0d %h/%h want 0123/0000", ok, w[0], w[1]);
        end
        for (int i = 0; i < 300; i++) begin
            if (DAC_SYNC_o !== 1'b1 || DAC_SCLK_o !== 1'b0) lows++;
            tick;
        end
        vec++; if (lows != 0) begin errs++; $display("FAIL od_idle_pins got %0d active cycles want 0", lows); end
        vec++; if (BUSY_o !== 1'b0) begin errs++; $display("FAIL od_after_busy got %b want 0", BUSY_o); end
        vec++; if (fd_cnt - fd0 != 1) begin errs++; $display("FAIL od_frame_done got %0d want 1", fd_cnt - fd0); end
        DATA_i = {16'h0000, 16'h0456}; DATA_VALID_i = 1'b1;
        tick;
        DATA_VALID_i = 1'b0;
        vec++; if (BUSY_o !== 1'b1) begin errs++; $display("FAIL od_second_busy got %b want 1", BUSY_o); end
        get_frame(w, ok);
        vec++; if (!ok || w[0] !== 16'h0456) begin errs++; $display("FAIL od_word2 got ok=%0d %h want 0456", ok, w[0]); end
    endtask

    task automatic test_reset_mid_shift;
        int budget = 20000, nf = 0, n = 0;
        logic ps;
        do_reset(1'b0);
        DATA_i = {16'hFFFF, 16'hFFFF}; DATA_VALID_i = 1'b1;
        tick;
        DATA_VALID_i = 1'b0;
        while (DAC_SYNC_o !== 1'b0 && budget > 0) begin tick; budget--; end
        ps = DAC_SCLK_o;
        while (budget > 0 && !(nf == 8 && DAC_SCLK_o === 1'b1)) begin
            tick; budget--;
            if (ps === 1'b1 && DAC_SCLK_o === 1'b0) nf++;
            ps = DAC_SCLK_o;
        end
        vec++; if (budget == 0 || DAC_DIN_o !== 2'b11) begin
            errs++; $display("FAIL rst_bit7_din got %b budget=%0d want 11", DAC_DIN_o, budget);
        end
        RST_i = 1'b1;
        tick;
        vec++; if (BUSY_o !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", BUSY_o); end
        tick;
        vec++; if (DAC_SCLK_o !== 1'b0 || DAC_SYNC_o !== 1'b1 || DAC_DIN_o !== 2'b00) begin
            errs++; $display("FAIL rst_pins got sclk=%b sync=%b din=%b want 0/1/00", DAC_SCLK_o, DAC_SYNC_o, DAC_DIN_o);
        end
        RST_i = 1'b0;
        while (DAC_SYNC_o !== 1'b0 && n < 20000) begin tick; n++; end
        vec++; if (n - 1 != STARTUP_CYC + SYNC_HI) begin
            errs++; $display("FAIL rst_restart got %0d want %0d", n - 1, STARTUP_CYC + SYNC_HI);
        end
    endtask

    initial begin
        test_reset;
        test_startup;
        test_bit_order;
        test_continuous;
        test_back_to_back;
        test_on_demand;
        test_reset_mid_shift;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
